sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Upstream feeder for the 4-bit parallel-in/parallel-out register stage.
//   Collects a serial bit stream into WIDTH-bit words and presents each completed word on a parallel bus.
//   Uses a valid/ready handshake, a one-word holding buffer, frame resync and sticky overrun detection.
//   Sits between the serial line front-end and the PIPO register bank.
// PARAMETERS
//   WIDTH      4   bits per word (>=2); dout width
//   MSB_FIRST  1   1: first serial bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//   clk          in   1                 single clock; all state updates on rising edge
//   rst          in   1                 asynchronous, active-high reset
//   sin          in   1                 serial data bit
//   sin_valid    in   1                 sin is sampled this cycle
//   sin_start    in   1                 frame sync: discard partial word; a valid bit this cycle is bit 0
//   dout         out  WIDTH             completed word (holding register)
//   dout_valid   out  1                 holding register full
//   dout_ready   in   1                 downstream accepts dout this cycle
//   bit_cnt      out  $clog2(WIDTH)     bits collected in the current partial word
//   overrun      out  1                 sticky: a completed word was dropped
//   overrun_clr  in   1                 clears overrun
// BEHAVIOUR
//   Reset (async, immediate): shift reg=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0.
//   Shift: on sin_valid, sin enters the shift reg and bit_cnt increments.
//     - MSB_FIRST=1: shift left, insert at LSB.
//     - MSB_FIRST=0: shift right, insert at MSB.
//   Completion occurs on a valid bit while bit_cnt==WIDTH-1; bit_cnt wraps to 0 on the same edge.
//   Latency: the completing edge loads dout with {shift contents, sin}; dout_valid=1 from the next cycle.
//   Holding buffer has two states, EMPTY (dout_valid=0) and FULL (dout_valid=1):
//     - EMPTY, completion -> FULL.
//     - FULL, dout_valid&dout_ready, no completion -> EMPTY.
//     - FULL, accept and completion on the same edge -> stays FULL with the new word (no bubble, no overrun).
//     - FULL, no accept, completion -> word dropped; dout unchanged; overrun<=1.
//   dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
//   dout_ready is ignored while EMPTY.
//   sin_start=1, sin_valid=0: partial discarded; bit_cnt<=0; shift reg<=0.
//   sin_start=1, sin_valid=1: partial discarded; sin becomes bit 0; bit_cnt<=1.
//     - No completion is possible on this edge (WIDTH>=2).
//   sin_valid=0 and no start: shift reg and bit_cnt hold.
//   overrun: set has priority over overrun_clr on the same edge; otherwise overrun_clr clears it.
//   Reset asserted mid-word or with dout_valid=1: everything is discarded; no word is emitted after release.
//   All outputs are registered; there are no combinational input-to-output paths.
// STRUCTURE
//   Shared package sipo_pkg:
//     - localparam CNT_W = $clog2(WIDTH) helper function.
//     - typedef enum {BUF_EMPTY, BUF_FULL}.
//   Sub-module sipo_shift_core (WIDTH, MSB_FIRST):
//     - Contains the shift register and bit counter.
//     - Outputs the partial word, bit_cnt and a one-cycle word_done pulse with the assembled word.
//   Top level: holding buffer FSM, handshake and overrun flag.
// TESTING
//   1. WIDTH=4, MSB_FIRST=1, bits 1,0,1,1 consecutive, dout_ready=1 -> dout=4'b1011, dout_valid high 1 cycle.
//   2. MSB_FIRST=0, bits 1,0,1,1 -> dout=4'b1101; bit_cnt steps 0,1,2,3,0.
//   3. dout_ready=0; send 0x5 then 0xA -> dout stays 0x5, overrun=1; overrun_clr alone clears it.
//      Clear and a new drop on the same edge -> overrun stays 1.
//   4. Word 0x3 held; dout_ready=1 on the same edge as completion of 0xC -> dout=0xC, dout_valid stays 1, overrun=0.
//   5. After 2 bits, sin_start with sin_valid and sin=1, then bits 0,0,1 -> dout=4'b1001; the partial is never emitted.
//   6. rst pulse after 3 bits and with dout_valid=1 -> all outputs 0 immediately.
//      Next 4 bits form a clean word.
//   7. sin_valid gaps of 0-3 idle cycles between bits -> the same words as back-to-back input.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// rtl/sipo_deserializer_pkg.sv - shared types and sizing helper for the SIPO deserializer
package sipo_pkg;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial-in / parallel-out bus bundle with master and slave views
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  import sipo_pkg::*;

  localparam int CNT_W = cnt_w(WIDTH);

  logic             sin;
  logic             sin_valid;
  logic             sin_start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             overrun_clr;

  modport master (
    output sin, sin_valid, sin_start, dout_ready, overrun_clr,
    input  dout, dout_valid, bit_cnt, overrun
  );

  modport slave (
    input  sin, sin_valid, sin_start, dout_ready, overrun_clr,
    output dout, dout_valid, bit_cnt, overrun
  );

endinterface

// File: rtl/sipo_deserializer_shift_core.sv
// rtl/sipo_deserializer_shift_core.sv - shift register and bit counter with word-complete pulse
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_sin,
  input  logic                      i_sin_valid,
  input  logic                      i_sin_start,
  output logic [cnt_w(WIDTH)-1:0]   o_bit_cnt,
  output logic                      o_word_done,
  output logic [WIDTH-1:0]          o_word
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_last;

  // A start pulse makes this cycle's bit land on an empty register as bit 0.
  always_comb begin
    w_base     = i_sin_start ? '0 : r_shift;
    w_cnt_base = i_sin_start ? '0 : r_cnt;
    w_shifted  = MSB_FIRST ? {w_base[WIDTH-2:0], i_sin} : {i_sin, w_base[WIDTH-1:1]};
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  end

  assign o_word_done = i_sin_valid & ~i_sin_start & w_last;
  assign o_word      = w_shifted;
  assign o_bit_cnt   = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_sin_valid) begin
      r_shift <= w_shifted;
      r_cnt   <= o_word_done ? '0 : w_cnt_base + 1'b1;
    end else if (i_sin_start) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-to-parallel word collector with one-word holding buffer and overrun flag
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sipo_deserializer_if.slave  io_bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  buf_state_t       r_state;
  buf_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovr;
  logic             w_load;
  logic             w_set_ovr;
  logic             w_word_done;
  logic [WIDTH-1:0] w_word;
  logic [CNT_W-1:0] w_bit_cnt;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sin       (io_bus.sin),
    .i_sin_valid (io_bus.sin_valid),
    .i_sin_start (io_bus.sin_start),
    .o_bit_cnt   (w_bit_cnt),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      BUF_EMPTY: begin
        if (w_word_done) begin
          w_load      = 1'b1;
          w_state_nxt = BUF_FULL;
        end
      end
      BUF_FULL: begin
        // Accept and completion on one edge swap the word in without a bubble.
        if (w_word_done) begin
          if (io_bus.dout_ready) begin
            w_load = 1'b1;
          end else begin
            w_set_ovr = 1'b1;
          end
        end else if (io_bus.dout_ready) begin
          w_state_nxt = BUF_EMPTY;
        end
      end
      default: w_state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BUF_EMPTY;
      r_dout  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_dout <= w_word;
      end
      if (w_set_ovr) begin
        r_ovr <= 1'b1;
      end else if (io_bus.overrun_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign io_bus.dout       = r_dout;
  assign io_bus.dout_valid = (r_state == BUF_FULL);
  assign io_bus.bit_cnt    = w_bit_cnt;
  assign io_bus.overrun    = r_ovr;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - randomized and directed checks of sipo_deserializer against a bit-queue model
module tb_sipo_deserializer;

  localparam int W = 4;

  logic clk;
  logic rst;
  logic sin;
  logic sin_valid;
  logic sin_start;
  logic dout_ready;
  logic overrun_clr;

  int total = 0;
  int bad   = 0;

  sipo_deserializer_if #(.WIDTH(W)) bus0 ();
  sipo_deserializer_if #(.WIDTH(W)) bus1 ();

  assign bus0.sin         = sin;
  assign bus0.sin_valid   = sin_valid;
  assign bus0.sin_start   = sin_start;
  assign bus0.dout_ready  = dout_ready;
  assign bus0.overrun_clr = overrun_clr;
  assign bus1.sin         = sin;
  assign bus1.sin_valid   = sin_valid;
  assign bus1.sin_start   = sin_start;
  assign bus1.dout_ready  = dout_ready;
  assign bus1.overrun_clr = overrun_clr;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus0)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Model: bits collected so far in the current frame; index 0 is the first bit.
  bit             q[$];
  logic [W-1:0]   exp_d [2];
  logic           exp_v [2];
  logic           exp_o [2];

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] words [2];
    logic         done;
    if (rst) begin
      q.delete();
      for (int k = 0; k < 2; k++) begin
        exp_d[k] = '0;
        exp_v[k] = 1'b0;
        exp_o[k] = 1'b0;
      end
    end else begin
      done     = 1'b0;
      words[0] = '0;
      words[1] = '0;
      if (sin_start) q.delete();
      if (sin_valid) begin
        q.push_back(sin);
        if (q.size() == W) begin
          for (int i = 0; i < W; i++) begin
            words[0][W-1-i] = q[i];
            words[1][i]     = q[i];
          end
          done = 1'b1;
          q.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        logic drop;
        drop = 1'b0;
        if (done) begin
          if (!exp_v[k] || dout_ready) begin
            exp_d[k] = words[k];
            exp_v[k] = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (exp_v[k] && dout_ready) begin
          exp_v[k] = 1'b0;
        end
        if (drop) exp_o[k] = 1'b1;
        else if (overrun_clr) exp_o[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("dout0",    int'(bus0.dout),       int'(exp_d[0]));
    chk("valid0",   int'(bus0.dout_valid), int'(exp_v[0]));
    chk("cnt0",     int'(bus0.bit_cnt),    q.size());
    chk("overrun0", int'(bus0.overrun),    int'(exp_o[0]));
    chk("dout1",    int'(bus1.dout),       int'(exp_d[1]));
    chk("valid1",   int'(bus1.dout_valid), int'(exp_v[1]));
    chk("cnt1",     int'(bus1.bit_cnt),    q.size());
    chk("overrun1", int'(bus1.overrun),    int'(exp_o[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic st, input logic clr);
    sin         = b;
    sin_valid   = 1'b1;
    sin_start   = st;
    overrun_clr = clr;
    tick();
    sin         = 1'b0;
    sin_valid   = 1'b0;
    sin_start   = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send(w[i], 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pat;
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0;
    dout_ready = 1'b1; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_dout",  int'(bus0.dout), 0);
    chk("rst_valid", int'(bus0.dout_valid), 0);
    chk("rst_cnt",   int'(bus0.bit_cnt), 0);
    chk("rst_ovr",   int'(bus0.overrun), 0);

    // Bits 1,0,1,1: MSB-first gives 1011, LSB-first gives 1101.
    pat = 4'b1011;
    for (int i = 0; i < W; i++) begin
      send(pat[W-1-i], 1'b0, 1'b0);
      chk("t2_cnt", int'(bus1.bit_cnt), (i + 1) % W);
    end
    chk("t1_dout",  int'(bus0.dout), 'hB);
    chk("t1_valid", int'(bus0.dout_valid), 1);
    chk("t2_dout",  int'(bus1.dout), 'hD);
    chk("t1_model", int'(exp_d[0]), 'hB);
    chk("t2_model", int'(exp_d[1]), 'hD);
    tick();
    chk("t1_valid_drop", int'(bus0.dout_valid), 0);

    // Overrun while stalled.
    dout_ready = 1'b0;
    send_word(4'h5);
    send_word(4'hA);
    chk("t3_dout_hold", int'(bus0.dout), 'h5);
    chk("t3_ovr",       int'(bus0.overrun), 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("t3_clr", int'(bus0.overrun), 0);
    send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    chk("t3_set_beats_clr", int'(bus0.overrun), 1);
    chk("t3_model_ovr",     int'(exp_o[0]), 1);
    overrun_clr = 1'b1; dout_ready = 1'b1; tick(); overrun_clr = 1'b0;
    chk("t3_drain", int'(bus0.dout_valid), 0);

    // Accept and completion on the same edge.
    dout_ready = 1'b0;
    send_word(4'h3);
    chk("t4_held", int'(bus0.dout), 'h3);
    send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b0);
    dout_ready = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    chk("t4_dout",  int'(bus0.dout), 'hC);
    chk("t4_valid", int'(bus0.dout_valid), 1);
    chk("t4_ovr",   int'(bus0.overrun), 0);
    tick();

    // Resync mid-word.
    send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    chk("t5_cnt", int'(bus0.bit_cnt), 1);
    chk("t5_no_partial", int'(bus0.dout_valid), 0);
    send(1'b0, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0);
    chk("t5_dout", int'(bus0.dout), 'h9);
    tick();

    // Reset mid-word with a held word and a pending overrun.
    dout_ready = 1'b0;
    send_word(4'h6);
    send_word(4'h9);
    send(1'b1, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_dout",  int'(bus0.dout), 0);
    chk("t6_valid", int'(bus0.dout_valid), 0);
    chk("t6_cnt",   int'(bus0.bit_cnt), 0);
    chk("t6_ovr",   int'(bus0.overrun), 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_nothing_after", int'(bus0.dout_valid), 0);
    dout_ready = 1'b1;
    send_word(4'hE);
    chk("t6_clean", int'(bus0.dout), 'hE);
    tick();

    // Idle gaps between bits.
    pat = 4'b1011;
    for (int i = 0; i < W; i++) begin
      send(pat[W-1-i], 1'b0, 1'b0);
      if (i < W - 1) repeat (i + 1) tick();
    end
    chk("t7_gap_dout",  int'(bus0.dout), 'hB);
    chk("t7_gap_valid", int'(bus0.dout_valid), 1);
    tick();

    for (int n = 0; n < 300; n++) begin
      dout_ready = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 3)) begin
        dout_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
